// File: rtl/uart_tx.sv
// uart_tx: 8N1 serializer with valid/ready byte intake and a CLKS_PER_BIT baud counter
module uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] data_in,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       Tx,
  output logic       busy,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n;
  logic [7:0] shift, shift_n;
  logic tc, tx_n, done_n;
  assign tc = cnt == CW'(CLKS_PER_BIT - 1);
  assign tx_ready = state == IDLE;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    cnt_n = tc ? '0 : cnt + CW'(1);
    idx_n = idx;
    shift_n = shift;
    case (state)
      IDLE: begin
        cnt_n = '0;
        idx_n = '0;
        state_n = tx_valid ? START : IDLE;
        shift_n = tx_valid ? data_in : shift;
      end
      START: begin
        state_n = tc ? DATA : START;
        idx_n = '0;
      end
      DATA: begin
        shift_n = tc ? shift >> 1 : shift;
        state_n = tc && idx == 3'd7 ? STOP : DATA;
        idx_n = tc && idx != 3'd7 ? idx + 3'd1 : idx;
      end
      STOP: state_n = tc ? IDLE : STOP;
      default: begin
        state_n = IDLE;
        cnt_n = '0;
        idx_n = '0;
      end
    endcase
    tx_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : IDLE_LEVEL;
    done_n = state == STOP && tc;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shift <= '0;
      Tx <= IDLE_LEVEL;
      done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      shift <= shift_n;
      Tx <= tx_n;
      done <= done_n;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed/randomized checks of uart_tx against a frame-level model and mid-bit receiver
module tb_uart_tx;
  localparam int CPB = 16;
  localparam int FRAME = 10 * CPB;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tx_valid = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic tx_ready, Tx, busy, done;
  int checks = 0;
  int errors = 0;
  logic [7:0] p, q;
  logic [7:0] lb [8];
  always #5 clk = ~clk;
  uart_tx #(.CLKS_PER_BIT(CPB), .IDLE_LEVEL(1'b1)) dut (
    .clk(clk),
    .reset(reset),
    .data_in(data_in),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .Tx(Tx),
    .busy(busy),
    .done(done)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic idle_state(input string tag);
    check({tag, "_tx"}, Tx, 1);
    check({tag, "_ready"}, tx_ready, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask
  // Entered at the first negedge after the accept edge; checks stop_at cycles of the frame.
  // A full frame ends on the done cycle, where the mid-bit receiver result is also checked.
  task automatic frame(input logic [7:0] b, input int poke, input int stop_at, output logic [7:0] poked);
    logic [9:0] fr;
    logic [7:0] rx;
    fr = {1'b1, b, 1'b0};
    rx = 8'h00;
    poked = 8'h00;
    for (int k = 0; k < stop_at; k++) begin
      check("tx_bit", Tx, fr[k / CPB]);
      check("busy_frame", busy, 1);
      check("ready_frame", tx_ready, 0);
      check("done_frame", done, 0);
      if (k % CPB == CPB / 2 && k / CPB >= 1 && k / CPB <= 8) rx[k / CPB - 1] = Tx;
      if (k == poke) begin
        poked = 8'($urandom);
        data_in = poked;
        tx_valid = 1'b1;
      end
      @(negedge clk);
    end
    if (stop_at == FRAME) begin
      check("done_pulse", done, 1);
      check("ready_after", tx_ready, 1);
      check("busy_after", busy, 0);
      check("tx_after", Tx, 1);
      check("rx_byte", rx, b);
    end
  endtask
  task automatic send(input logic [7:0] b);
    logic [7:0] d;
    data_in = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    data_in = 8'($urandom);
    frame(b, -1, FRAME, d);
    @(negedge clk);
    check("done_once", done, 0);
  endtask
  task automatic abort_at(input logic [7:0] b, input int k);
    logic [7:0] d;
    data_in = b;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    frame(b, -1, k, d);
    #2 reset = 1'b1;
    #1 idle_state("reset_async");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      idle_state("post_abort");
    end
  endtask
  initial begin
    repeat (3) @(negedge clk);
    idle_state("in_reset");
    reset = 1'b0;
    repeat (50) begin
      @(negedge clk);
      idle_state("idle50");
    end
    send(8'hA5);
    data_in = 8'h00;
    tx_valid = 1'b1;
    @(negedge clk);
    frame(8'h00, -1, FRAME, p);
    data_in = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    frame(8'hFF, -1, FRAME, p);
    @(negedge clk);
    check("b2b_done_once", done, 0);
    p = 8'($urandom);
    data_in = p;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    frame(p, 37, FRAME, q);
    @(negedge clk);
    tx_valid = 1'b0;
    frame(q, -1, FRAME, p);
    @(negedge clk);
    abort_at(8'h3C, 4 * CPB + 5);
    send(8'h3C);
    abort_at(8'($urandom), 3);
    lb[0] = 8'h00;
    lb[1] = 8'h55;
    lb[2] = 8'h80;
    lb[3] = 8'hFF;
    for (int i = 4; i < 8; i++) lb[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) send(lb[i]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
